// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue: enqueue side from fetch, dequeue side to decode.
interface fetch_queue_if #(
    parameter int WORD_W = 32
);
    logic              enq_valid;
    logic              enq_ready;
    logic [WORD_W-1:0] enq_instr;
    logic [WORD_W-1:0] enq_pc;
    logic [WORD_W-1:0] enq_pc_p4;
    logic [WORD_W-1:0] enq_nxt_pc;
    logic              deq_valid;
    logic              deq_ready;
    logic [WORD_W-1:0] deq_instr;
    logic [WORD_W-1:0] deq_pc;
    logic [WORD_W-1:0] deq_pc_p4;
    logic [WORD_W-1:0] deq_nxt_pc;

    modport slave (
        input  enq_valid, enq_instr, enq_pc, enq_pc_p4, enq_nxt_pc, deq_ready,
        output enq_ready, deq_valid, deq_instr, deq_pc, deq_pc_p4, deq_nxt_pc
    );

    modport master (
        output enq_valid, enq_instr, enq_pc, enq_pc_p4, enq_nxt_pc, deq_ready,
        input  enq_ready, deq_valid, deq_instr, deq_pc, deq_pc_p4, deq_nxt_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction fetch queue between fetch and decode, with flush and freeze.
// Define FETCHQ_BYPASS_EN to let an empty queue pass the incoming instruction straight to decode.
module fetch_queue #(
    parameter  int DEPTH  = 4,
    parameter  int WORD_W = 32,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          flush,
    input  logic          freeze,
    fetch_queue_if.slave  fq,
    output logic [CW-1:0] count
);
    localparam int EW = 4 * WORD_W;

    logic [EW-1:0] mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    logic          empty_s;
    logic          full_s;
    logic          bypass_s;
    logic          enq_ready_s;
    logic          deq_valid_s;
    logic          push_s;
    logic          pop_s;
    logic          direct_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic [EW-1:0] enq_entry_s;
    logic [EW-1:0] head_s;
    logic [EW-1:0] deq_data_s;

    assign enq_entry_s = {fq.enq_instr, fq.enq_pc, fq.enq_pc_p4, fq.enq_nxt_pc};
    assign head_s      = mem_r[rd_ptr_r];

    // Handshake decode, bypass selection and head presentation
    always_comb begin
        empty_s = (count_r == {CW{1'b0}});
        full_s  = (count_r == CW'(DEPTH));
`ifdef FETCHQ_BYPASS_EN
        bypass_s = empty_s && fq.enq_valid && !freeze && !flush;
`else
        bypass_s = 1'b0;
`endif
        enq_ready_s = !full_s && !freeze && !flush;
        deq_valid_s = !empty_s || bypass_s;
        push_s      = fq.enq_valid && enq_ready_s;
        pop_s       = deq_valid_s && fq.deq_ready && !freeze && !flush;
        // A bypassed instruction taken by decode never touches storage
        direct_s    = bypass_s && fq.deq_ready;
        wr_en_s     = push_s && !direct_s;
        rd_en_s     = pop_s && !direct_s;
        if (!empty_s) begin
            deq_data_s = head_s;
        end else if (bypass_s) begin
            deq_data_s = enq_entry_s;
        end else begin
            deq_data_s = {EW{1'b0}};
        end
    end

    assign fq.enq_ready  = enq_ready_s;
    assign fq.deq_valid  = deq_valid_s;
    assign fq.deq_instr  = deq_data_s[4*WORD_W-1:3*WORD_W];
    assign fq.deq_pc     = deq_data_s[3*WORD_W-1:2*WORD_W];
    assign fq.deq_pc_p4  = deq_data_s[2*WORD_W-1:WORD_W];
    assign fq.deq_nxt_pc = deq_data_s[WORD_W-1:0];
    assign count         = count_r;

    // Pointer and occupancy state; reset and flush both empty the queue
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (!freeze) begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end else begin
            rd_ptr_r <= rd_ptr_r;
            wr_ptr_r <= wr_ptr_r;
            count_r  <= count_r;
        end
    end

    // Entry storage; contents are don't-care once pointers discard them
    always_ff @(posedge CLK) begin
        if (!RST && wr_en_s) begin
            mem_r[wr_ptr_r] <= enq_entry_s;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue;
    localparam int DEPTH  = 4;
    localparam int WORD_W = 32;
    localparam int CW     = $clog2(DEPTH + 1);
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] nxt;
    } entry_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          flush;
    logic          freeze;
    logic [CW-1:0] count;

    fetch_queue_if #(.WORD_W(WORD_W)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .flush  (flush),
        .freeze (freeze),
        .fq     (bus),
        .count  (count)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    bit          last_push;
    entry_t      mq[$];
    logic [31:0] consumed[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit r, input logic [31:0] instr, input logic [31:0] pc);
        bus.enq_valid  = v;
        bus.deq_ready  = r;
        bus.enq_instr  = instr;
        bus.enq_pc     = pc;
        bus.enq_pc_p4  = pc + 32'd4;
        bus.enq_nxt_pc = pc + 32'd8;
    endtask

    // One clock cycle: compare outputs against the model, then advance the model at the edge.
    task automatic cycle();
        entry_t e_in;
        entry_t head;
        bit     er, dv, byp, pop, push;
        #1;
        e_in = {bus.enq_instr, bus.enq_pc, bus.enq_pc_p4, bus.enq_nxt_pc};
        er   = (mq.size() != DEPTH) && !freeze && !flush;
        byp  = BYP && (mq.size() == 0) && bus.enq_valid && !freeze && !flush;
        dv   = (mq.size() != 0) || byp;
        if (mq.size() != 0)  head = mq[0];
        else if (byp)        head = e_in;
        else                 head = '0;
        if (chk_en) begin
            check_eq("count",      32'(count), 32'(mq.size()));
            check_eq("enq_ready",  32'(bus.enq_ready), 32'(er));
            check_eq("deq_valid",  32'(bus.deq_valid), 32'(dv));
            check_eq("deq_instr",  bus.deq_instr, head.instr);
            check_eq("deq_pc",     bus.deq_pc, head.pc);
            check_eq("deq_pc_p4",  bus.deq_pc_p4, head.pc4);
            check_eq("deq_nxt_pc", bus.deq_nxt_pc, head.nxt);
        end
        pop  = dv && bus.deq_ready && !freeze && !flush;
        push = bus.enq_valid && er;
        if (pop && !RST) consumed.push_back(bus.deq_instr);
        @(posedge CLK);
        last_push = push && !RST;
        if (RST || flush) begin
            mq.delete();
        end else if (!freeze) begin
            if (!(pop && byp)) begin
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back(e_in);
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        int nb;
        logic [31:0] exp_seq [8];

        RST = 1'b1; flush = 1'b0; freeze = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) cycle();
        RST = 1'b0; chk_en = 1'b1;
        #1;
        check_eq("rst_count",     32'(count), 32'd0);
        check_eq("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
        check_eq("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
        check_eq("rst_deq_instr", bus.deq_instr, 32'd0);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'hA0 + 32'(i), 32'(4 * i));
            cycle();
        end
        #1;
        check_eq("fill_count",     32'(count), 32'd4);
        check_eq("fill_enq_ready", 32'(bus.enq_ready), 32'd0);
        check_eq("fill_head",      bus.deq_instr, 32'hA0);

        // Drain with refill into freed slots; pointers wrap through 0
        consumed.delete();
        nb = 0;
        for (int k = 0; k < 20 && consumed.size() < 8; k++) begin
            drive(nb < 4, 1'b1, 32'hB0 + 32'(nb), 32'h100 + 32'(4 * nb));
            cycle();
            if (last_push) nb++;
        end
        for (int i = 0; i < 4; i++) begin
            exp_seq[i]     = 32'hA0 + 32'(i);
            exp_seq[i + 4] = 32'hB0 + 32'(i);
        end
        check_eq("drain_len", 32'(consumed.size()), 32'd8);
        for (int i = 0; i < 8 && i < consumed.size(); i++) check_eq("drain_order", consumed[i], exp_seq[i]);

        // Flush with simultaneous push and pop
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'hF0 + 32'(i), 32'h300 + 32'(4 * i));
            cycle();
        end
        #1;
        check_eq("flush_pre_count", 32'(count), 32'd3);
        flush = 1'b1;
        drive(1'b1, 1'b1, 32'h99, 32'h400);
        cycle();
        flush = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("flush_count",     32'(count), 32'd0);
        check_eq("flush_deq_valid", 32'(bus.deq_valid), 32'd0);
        check_eq("flush_deq_instr", bus.deq_instr, 32'd0);

        // Freeze holds everything
        drive(1'b1, 1'b0, 32'hC0, 32'h500); cycle();
        drive(1'b1, 1'b0, 32'hC1, 32'h504); cycle();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h77, 32'h600);
            #1;
            check_eq("frz_count",     32'(count), 32'd2);
            check_eq("frz_head",      bus.deq_instr, 32'hC0);
            check_eq("frz_enq_ready", 32'(bus.enq_ready), 32'd0);
            cycle();
        end
        freeze = 1'b0;

        // Simultaneous push and pop
        drive(1'b1, 1'b1, 32'hD0, 32'h700); cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("pp_count", 32'(count), 32'd2);
        check_eq("pp_head",  bus.deq_instr, 32'hC1);
        consumed.delete();
        drive(1'b0, 1'b1, 32'h0, 32'h0);
        cycle();
        #1;
        check_eq("pp_head_d0", bus.deq_instr, 32'hD0);
        cycle();
        check_eq("pp_pops", 32'(consumed.size()), 32'd2);
        if (consumed.size() == 2) check_eq("pp_order", consumed[1], 32'hD0);

        // Empty-queue latency: bypass or one cycle
        drive(1'b1, 1'b1, 32'hE0, 32'h800);
        #1;
        if (BYP) begin
            check_eq("byp_deq_valid", 32'(bus.deq_valid), 32'd1);
            check_eq("byp_deq_instr", bus.deq_instr, 32'hE0);
            cycle();
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            #1;
            check_eq("byp_count", 32'(count), 32'd0);
        end else begin
            check_eq("nobyp_deq_valid0", 32'(bus.deq_valid), 32'd0);
            cycle();
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            #1;
            check_eq("nobyp_deq_valid1", 32'(bus.deq_valid), 32'd1);
            check_eq("nobyp_deq_instr",  bus.deq_instr, 32'hE0);
        end

        // Reset mid-operation discards entries
        drive(1'b1, 1'b0, 32'h11, 32'h900); cycle();
        drive(1'b1, 1'b0, 32'h12, 32'h904); cycle();
        RST = 1'b1; cycle(); RST = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("midrst_count", 32'(count), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            RST    = ($urandom_range(0, 59) == 0);
            flush  = ($urandom_range(0, 24) == 0);
            freeze = ($urandom_range(0, 9) == 0);
            if (k < 200) drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom, $urandom & 32'hFFFF_FFFC);
            else         drive($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom & 32'hFFFF_FFFC);
            cycle();
        end
        RST = 1'b0; flush = 1'b0; freeze = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
